// File: rtl/wb_spi_master_if.sv
// Wishbone classic slave bus bundle for wb_spi_master.
interface wb_spi_master_if;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;
  logic        wb_stall;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_dat_r, wb_ack, wb_stall, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_dat_r, wb_ack, wb_stall, wb_err
  );
endinterface

// File: rtl/wb_spi_master.sv
// Wishbone-controlled SPI master: byte FIFOs, programmable SCK divider,
// all four CPOL/CPHA modes, NUM_CS chip selects and a level interrupt.
module wb_spi_master_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Callers only push when not full and only pop when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
endmodule

module wb_spi_master #(
  parameter int unsigned NUM_CS         = 1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [15:0] INITIAL_CLKDIV = 16'd62
) (
  input  logic              clk,
  input  logic              rst,
  wb_spi_master_if.slave    wb,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              irq
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [8:0]    ctrl;
  logic [15:0]   clkdiv;
  logic          tx_ovf;
  logic [31:0]   rdata;
  logic [31:0]   status;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_dout, rx_dout;
  logic [LW-1:0] tx_level, rx_level;

  logic [15:0]   div_cnt;
  logic [3:0]    half_cnt;
  logic [7:0]    tx_sr, rx_sr;
  logic          cpha_l;
  logic [15:0]   clkdiv_l;
  logic          half_end;
  logic          busy;

  logic          req, wr, rd, data_sel;
  logic          unused_bits;

  wire ctrl_cpha      = ctrl[0];
  wire ctrl_cpol      = ctrl[1];
  wire ctrl_en        = ctrl[2];
  wire [2:0] cs_idx   = ctrl[5:3];
  wire ctrl_cs_assert = ctrl[6];
  wire ie_txdone      = ctrl[7];
  wire ie_rx          = ctrl[8];

  assign unused_bits = ^{wb.wb_sel, wb.wb_dat_w[31:16]};

  assign req      = wb.wb_cyc & wb.wb_stb;
  assign wr       = req & wb.wb_we;
  assign rd       = req & ~wb.wb_we;
  assign data_sel = (wb.wb_adr == 2'd2);

  assign tx_push = wr & data_sel & ~tx_full;
  assign rx_pop  = rd & data_sel & ~rx_empty;
  assign tx_pop  = (state == LOAD);
  assign rx_push = (state == DONE) & ~rx_full;

  wb_spi_master_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wb.wb_dat_w[7:0]),
    .dout(tx_dout), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  wb_spi_master_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sr),
    .dout(rx_dout), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  assign busy   = (state != IDLE);
  assign status = {9'b0, 7'(rx_level), 1'b0, 7'(tx_level), 2'b0,
                   tx_ovf, rx_empty, rx_full, tx_empty, tx_full, busy};

  always_comb begin
    rdata = '0;
    case (wb.wb_adr)
      2'd0: rdata = {23'b0, ctrl};
      2'd1: rdata = {16'b0, clkdiv};
      2'd2: rdata = {24'b0, (rx_empty ? 8'h00 : rx_dout)};
      2'd3: rdata = status;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl      <= '0;
      clkdiv    <= INITIAL_CLKDIV;
      tx_ovf    <= 1'b0;
      wb.wb_ack   <= 1'b0;
      wb.wb_dat_r <= '0;
    end else begin
      wb.wb_ack <= req;
      if (rd) wb.wb_dat_r <= rdata;
      if (wr && wb.wb_adr == 2'd0) ctrl   <= wb.wb_dat_w[8:0];
      if (wr && wb.wb_adr == 2'd1) clkdiv <= wb.wb_dat_w[15:0];
      if (wr && data_sel && tx_full) tx_ovf <= 1'b1;
      else if (wr && wb.wb_adr == 2'd3 && wb.wb_dat_w[5]) tx_ovf <= 1'b0;
    end
  end

  assign wb.wb_stall = 1'b0;
  assign wb.wb_err   = 1'b0;

  assign half_end = (state == SHIFT) && (div_cnt == clkdiv_l);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_en && !tx_empty && !rx_full) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (half_end && half_cnt == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Even half-periods end on a leading edge; CPHA decides whether that
  // edge samples MISO or advances MOSI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_l   <= 1'b0;
      clkdiv_l <= '0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: spi_sck <= ctrl_cpol;
        LOAD: begin
          cpha_l   <= ctrl_cpha;
          clkdiv_l <= clkdiv;
          div_cnt  <= '0;
          half_cnt <= '0;
          spi_sck  <= ctrl_cpol;
          if (!ctrl_cpha) begin
            spi_mosi <= tx_dout[7];
            tx_sr    <= {tx_dout[6:0], 1'b0};
          end else begin
            tx_sr    <= tx_dout;
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 4'd1;
            spi_sck  <= ~spi_sck;
            if (half_cnt[0] == cpha_l) begin
              rx_sr <= {rx_sr[6:0], spi_miso};
            end else begin
              spi_mosi <= tx_sr[7];
              tx_sr    <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spi_cs_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (ctrl_cs_assert && cs_idx == 3'(i)) spi_cs_n[i] = 1'b0;
    end
  end

  assign irq = (ie_txdone & tx_empty & ~busy) | (ie_rx & ~rx_empty);
endmodule

// File: tb/tb_wb_spi_master.sv
// Directed self-checking bench for wb_spi_master (NUM_CS=4, FIFO_DEPTH=16).
module tb_wb_spi_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck, spi_mosi, spi_miso, irq;
  logic [3:0] spi_cs_n;
  logic       loopback = 1'b1;
  logic       mode3_en = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_sr = 8'h3C;
  logic [7:0] mosi_cap = 8'h00;
  logic [31:0] rdv;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned busy_cnt, rise_cnt, low_cnt;
  logic        prev_sck, got;

  wb_spi_master_if wbi ();

  wb_spi_master #(.NUM_CS(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wb(wbi),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  assign spi_miso = loopback ? spi_mosi : slave_bit;

  // Mode-3 slave: next bit on leading (falling) edge; capture MOSI on rising.
  always @(negedge spi_sck) if (mode3_en) begin
    slave_bit <= slave_sr[7];
    slave_sr  <= {slave_sr[6:0], 1'b0};
  end
  always @(posedge spi_sck) if (mode3_en) mosi_cap <= {mosi_cap[6:0], spi_mosi};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    @(negedge clk);
    wbi.wb_adr = adr; wbi.wb_dat_w = dat; wbi.wb_we = 1'b1;
    wbi.wb_cyc = 1'b1; wbi.wb_stb = 1'b1;
    @(negedge clk);
    chk("wr_ack", {31'b0, wbi.wb_ack}, 32'd1);
    wbi.wb_cyc = 1'b0; wbi.wb_stb = 1'b0; wbi.wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat);
    @(negedge clk);
    wbi.wb_adr = adr; wbi.wb_we = 1'b0;
    wbi.wb_cyc = 1'b1; wbi.wb_stb = 1'b1;
    @(negedge clk);
    chk("rd_ack", {31'b0, wbi.wb_ack}, 32'd1);
    dat = wbi.wb_dat_r;
    wbi.wb_cyc = 1'b0; wbi.wb_stb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wbi.wb_adr = '0; wbi.wb_dat_w = '0; wbi.wb_sel = 4'hF;
    wbi.wb_cyc = 1'b0; wbi.wb_stb = 1'b0; wbi.wb_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  {31'b0, wbi.wb_ack}, 32'd0);
    chk("rst_datr", wbi.wb_dat_r, 32'd0);
    chk("rst_sck",  {31'b0, spi_sck}, 32'd0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("rst_csn",  {28'b0, spi_cs_n}, 32'hF);
    chk("rst_irq",  {31'b0, irq}, 32'd0);
    rst = 1'b0;

    wb_read(2'd1, rdv); chk("clkdiv_rst", rdv, 32'd62);
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, wbi.wb_ack}, 32'd0);
    wb_read(2'd3, rdv); chk("status_rst", rdv, 32'h14);
    wb_read(2'd0, rdv); chk("ctrl_rst", rdv, 32'h0);

    // Mode 0, CLKDIV=1, loopback
    wb_write(2'd1, 32'd1);
    wb_write(2'd0, 32'h44);
    chk("cs0_asserted", {28'b0, spi_cs_n}, 32'hE);
    wb_write(2'd2, 32'hA5);
    busy_cnt = 0; rise_cnt = 0; prev_sck = spi_sck;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dut.busy) busy_cnt++;
      if (spi_sck && !prev_sck) rise_cnt++;
      prev_sck = spi_sck;
    end
    chk("m0_busy_cycles", busy_cnt, 32'd34);
    chk("m0_sck_rises", rise_cnt, 32'd8);
    wb_read(2'd3, rdv); chk("m0_status", rdv, 32'h0001_0004);
    wb_read(2'd2, rdv); chk("m0_rx", rdv, 32'hA5);
    wb_read(2'd3, rdv); chk("m0_status_after", rdv, 32'h14);

    // Mode 3 with slave returning 0x3C
    wb_write(2'd0, 32'h47);
    repeat (2) @(negedge clk);
    chk("m3_sck_idle", {31'b0, spi_sck}, 32'd1);
    loopback = 1'b0; mode3_en = 1'b1;
    wb_write(2'd2, 32'hFF);
    repeat (40) @(negedge clk);
    chk("m3_not_busy", {31'b0, dut.busy}, 32'd0);
    chk("m3_sck_idle_after", {31'b0, spi_sck}, 32'd1);
    chk("m3_mosi", {24'b0, mosi_cap}, 32'hFF);
    wb_read(2'd2, rdv); chk("m3_rx", rdv, 32'h3C);
    mode3_en = 1'b0; loopback = 1'b1;

    // TX overflow with engine disabled
    wb_write(2'd0, 32'h0);
    for (int i = 0; i < 17; i++) wb_write(2'd2, 32'(i));
    wb_read(2'd3, rdv); chk("ovf_status", rdv, 32'h0000_1032);
    wb_write(2'd3, 32'h20);
    wb_read(2'd3, rdv); chk("ovf_cleared", rdv, 32'h0000_1012);

    // Drain TX into RX until RX full, then check stall
    wb_write(2'd0, 32'h04);
    repeat (620) @(negedge clk);
    wb_read(2'd3, rdv); chk("rx_full_status", rdv, 32'h0010_000C);
    wb_write(2'd2, 32'h77);
    repeat (50) @(negedge clk);
    wb_read(2'd3, rdv); chk("stall_status", rdv, 32'h0010_0108);
    wb_read(2'd2, rdv); chk("stall_pop", rdv, 32'h00);
    repeat (50) @(negedge clk);
    wb_read(2'd3, rdv); chk("one_byte_moved", rdv, 32'h0010_000C);
    for (int i = 1; i < 16; i++) begin
      wb_read(2'd2, rdv); chk("drain", rdv, 32'(i));
    end
    wb_read(2'd2, rdv); chk("drain_last", rdv, 32'h77);
    wb_read(2'd2, rdv); chk("rx_empty_read", rdv, 32'h0);
    wb_read(2'd3, rdv); chk("rx_empty_status", rdv, 32'h14);

    // Chip selects
    wb_write(2'd0, 32'h50);
    chk("cs_idx2", {28'b0, spi_cs_n}, 32'hB);
    wb_write(2'd0, 32'h68);
    chk("cs_idx5", {28'b0, spi_cs_n}, 32'hF);

    // irq on last DONE of three queued bytes
    wb_write(2'd0, 32'h0);
    wb_write(2'd2, 32'h11);
    wb_write(2'd2, 32'h22);
    wb_write(2'd2, 32'h33);
    wb_write(2'd0, 32'h84);
    low_cnt = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (irq) got = 1'b1;
      else low_cnt++;
    end
    chk("irq_seen", {31'b0, got}, 32'd1);
    chk("irq_delay", low_cnt, 32'd104);

    // Reset mid-byte
    wb_write(2'd0, 32'hC4);
    wb_write(2'd2, 32'h5A);
    repeat (10) @(negedge clk);
    wb_read(2'd3, rdv); chk("midbyte_busy", {31'b0, rdv[0]}, 32'd1);
    chk("midbyte_cs", {28'b0, spi_cs_n}, 32'hE);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_datr", wbi.wb_dat_r, 32'd0);
    chk("arst_sck",  {31'b0, spi_sck}, 32'd0);
    chk("arst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("arst_csn",  {28'b0, spi_cs_n}, 32'hF);
    chk("arst_irq",  {31'b0, irq}, 32'd0);
    chk("arst_busy", {31'b0, dut.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(2'd3, rdv); chk("post_rst_status", rdv, 32'h14);
    wb_read(2'd1, rdv); chk("post_rst_clkdiv", rdv, 32'd62);
    wb_read(2'd0, rdv); chk("post_rst_ctrl", rdv, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
